// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT datapath constants, loader state type and address helpers
package fft_pkg;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    LAST = 2'd1,
    HOLD = 2'd2
  } loader_state_t;

  // Swaps the two address bits; decimation-in-time wants inputs in this order.
  function automatic logic [ADDR_W-1:0] bitrev2(input logic [ADDR_W-1:0] addr);
    return {addr[0], addr[1]};
  endfunction

endpackage

// File: rtl/fft_frame_loader.sv
// rtl/fft_frame_loader.sv - writes a four-sample frame into the sample store and holds it until acked
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int N      = 16,
  parameter bit BITREV = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [N-1:0]      i_sample,
  output logic              o_ready,
  input  logic              i_flush,
  output logic [N-1:0]      o_word,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_we,
  output logic              o_frame_valid,
  input  logic              i_frame_ack,
  output logic [7:0]        o_frames
);

  loader_state_t     state;
  loader_state_t     state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              accept;

  // o_ready is only ever high in FILL, so it alone qualifies the handshake.
  assign accept = i_valid && o_ready && !i_flush;

  always_comb begin
    state_nxt = state;
    if (i_flush) begin
      state_nxt = FILL;
    end else begin
      unique case (state)
        FILL:    if (accept && cnt == ADDR_W'(DEPTH - 1)) state_nxt = LAST;
        LAST:    state_nxt = HOLD;
        HOLD:    if (i_frame_ack) state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= FILL;
      cnt           <= '0;
      o_ready       <= 1'b0;
      o_word        <= '0;
      o_address     <= '0;
      o_we          <= 1'b0;
      o_frame_valid <= 1'b0;
      o_frames      <= 8'd0;
    end else begin
      state         <= state_nxt;
      o_ready       <= (state_nxt == FILL);
      o_frame_valid <= (state_nxt == HOLD);
      o_we          <= accept;

      if (accept) begin
        o_word    <= i_sample;
        o_address <= BITREV ? bitrev2(cnt) : cnt;
        cnt       <= cnt + 1'b1;
      end

      // A flush abandons the partial frame; cnt is also forced to 0 while held.
      if (i_flush || state == HOLD) begin
        cnt <= '0;
      end

      if (state == LAST && !i_flush) begin
        o_frames <= o_frames + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// tb/tb_fft_frame_loader.sv - directed bench for fft_frame_loader with a frame-level reference model
module tb_fft_frame_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        flush;
  logic        ack;
  logic [15:0] sample;

  logic        br_ready, br_we, br_fv;
  logic [15:0] br_word;
  logic [1:0]  br_address;
  logic [7:0]  br_frames;
  logic        nat_ready, nat_we, nat_fv;
  logic [15:0] nat_word;
  logic [1:0]  nat_address;
  logic [7:0]  nat_frames;

  always #5 clk = ~clk;

  fft_frame_loader #(.N(16), .BITREV(1'b1)) dut_br (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_sample(sample),
    .o_ready(br_ready), .i_flush(flush), .o_word(br_word), .o_address(br_address),
    .o_we(br_we), .o_frame_valid(br_fv), .i_frame_ack(ack), .o_frames(br_frames)
  );

  fft_frame_loader #(.N(16), .BITREV(1'b0)) dut_nat (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_sample(sample),
    .o_ready(nat_ready), .i_flush(flush), .o_word(nat_word), .o_address(nat_address),
    .o_we(nat_we), .o_frame_valid(nat_fv), .i_frame_ack(ack), .o_frames(nat_frames)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Frame-level model: count samples taken, then one settling cycle, then hold until ack.
  bit          m_ready, m_we, m_fv, m_wait, m_acc;
  logic [15:0] m_word;
  int          m_taken, m_frames, m_addr_br, m_addr_nat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 0; m_we = 0; m_fv = 0; m_wait = 0;
      m_word = 16'h0; m_taken = 0; m_frames = 0; m_addr_br = 0; m_addr_nat = 0;
    end else begin
      m_acc = valid && m_ready;
      if (flush) begin
        m_taken = 0; m_we = 0; m_fv = 0; m_wait = 0; m_ready = 1;
      end else begin
        m_we = m_acc;
        if (m_acc) begin
          m_word     = sample;
          m_addr_nat = m_taken;
          m_addr_br  = ((m_taken % 2) * 2) + (m_taken / 2);
          m_taken    = m_taken + 1;
        end
        if (m_wait) begin
          m_fv = 1; m_wait = 0; m_ready = 0;
          m_frames = (m_frames + 1) % 256;
        end else if (m_fv) begin
          if (ack) begin
            m_fv = 0; m_taken = 0; m_ready = 1;
          end
        end else if (m_taken == 4) begin
          m_wait = 1; m_ready = 0;
        end else begin
          m_ready = 1;
        end
      end
    end
  end

  logic [17:0] br_log[$];
  logic [17:0] nat_log[$];

  always @(negedge clk) begin
    chk("br_ready", br_ready, m_ready);
    chk("br_we", br_we, m_we);
    chk("br_frame_valid", br_fv, m_fv);
    chk("br_frames", br_frames, m_frames[7:0]);
    chk("br_word", br_word, m_word);
    chk("br_address", br_address, m_addr_br[1:0]);
    chk("nat_ready", nat_ready, m_ready);
    chk("nat_we", nat_we, m_we);
    chk("nat_frame_valid", nat_fv, m_fv);
    chk("nat_frames", nat_frames, m_frames[7:0]);
    chk("nat_word", nat_word, m_word);
    chk("nat_address", nat_address, m_addr_nat[1:0]);
    if (rst_n && br_we)  br_log.push_back({br_address, br_word});
    if (rst_n && nat_we) nat_log.push_back({nat_address, nat_word});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] s2[4]     = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [1:0]  br_ord[4] = '{2'd0, 2'd2, 2'd1, 2'd3};
  logic [15:0] s3[4]     = '{16'h7777, 16'h8888, 16'h9999, 16'hBBBB};
  int          base_br, base_nat, seen;

  initial begin
    rst_n = 0; valid = 0; flush = 0; ack = 0; sample = 16'h0;
    repeat (3) step();
    chk("rst_ready", br_ready, 1'b0);
    chk("rst_we", br_we, 1'b0);
    chk("rst_frame_valid", br_fv, 1'b0);
    chk("rst_frames", br_frames, 8'd0);
    chk("rst_word", br_word, 16'h0);
    chk("rst_address", br_address, 2'd0);
    rst_n = 1;
    step();
    chk("ready_after_release", br_ready, 1'b1);
    chk("no_we_before_accept", br_we, 1'b0);

    // Bit-reversed frame on consecutive cycles
    base_br = br_log.size(); base_nat = nat_log.size();
    for (int i = 0; i < 4; i++) begin
      valid = 1; sample = s2[i]; step();
    end
    valid = 0;
    chk("last_we", br_we, 1'b1);
    chk("last_ready_low", br_ready, 1'b0);
    chk("fv_not_yet", br_fv, 1'b0);
    step();
    chk("fv_rise", br_fv, 1'b1);
    chk("frames_one", br_frames, 8'd1);
    chk("br_write_count", br_log.size(), base_br + 4);
    for (int i = 0; i < 4; i++) begin
      chk("br_frame_write", br_log[base_br + i], {br_ord[i], s2[i]});
      chk("nat_frame_write", nat_log[base_nat + i], {2'(i), s2[i]});
    end

    // Backpressure while holding the frame
    valid = 1; sample = 16'h5555;
    repeat (3) step();
    chk("hold_no_we", br_we, 1'b0);
    chk("hold_ready_low", br_ready, 1'b0);
    ack = 1; step(); ack = 0;
    chk("ack_ready", br_ready, 1'b1);
    chk("ack_fv_low", br_fv, 1'b0);
    step(); valid = 0;
    chk("bp_we", br_we, 1'b1);
    chk("bp_word", br_word, 16'h5555);
    chk("bp_address", br_address, 2'd0);

    // Flush after two accepts, with a sample presented alongside
    valid = 1; sample = 16'h6666; step();
    flush = 1; sample = 16'hAAAA; step();
    flush = 0; valid = 0;
    chk("flush_no_we", br_we, 1'b0);
    chk("flush_frames", br_frames, 8'd1);
    step();
    seen = 0;
    foreach (br_log[i]) if (br_log[i][15:0] == 16'hAAAA) seen++;
    chk("flush_discard", seen, 0);

    // Natural order with gaps, starting right after the flush
    base_br = br_log.size(); base_nat = nat_log.size();
    for (int i = 0; i < 4; i++) begin
      valid = 1; sample = s3[i]; step();
      valid = 0; step();
    end
    chk("gap_frames", nat_frames, 8'd2);
    chk("gap_fv", nat_fv, 1'b1);
    chk("gap_write_count", nat_log.size(), base_nat + 4);
    chk("post_flush_br_addr0", br_log[base_br], {2'd0, 16'h7777});
    for (int i = 0; i < 4; i++)
      chk("gap_nat_write", nat_log[base_nat + i], {2'(i), s3[i]});

    // Asynchronous reset while holding
    #2 rst_n = 0;
    #1;
    chk("async_fv", br_fv, 1'b0);
    chk("async_frames", br_frames, 8'd0);
    chk("async_ready", nat_ready, 1'b0);
    @(posedge clk); #1 rst_n = 1;

    // Continuous stream with ack held high
    base_br = br_log.size(); base_nat = nat_log.size();
    ack = 1;
    for (int j = 0; j < 10; j++) begin
      valid = 1; sample = 16'hC000 + 16'(j); step();
    end
    chk("restart_br", br_log[base_br], {2'd0, 16'hC001});
    chk("restart_nat", nat_log[base_nat], {2'd0, 16'hC001});
    chk("period_six", br_log[base_br + 4], {2'd0, 16'hC007});

    // Long stream to exercise the frame counter wrap
    for (int j = 0; j < 1560; j++) begin
      sample = 16'(j * 7); step();
    end
    valid = 0; ack = 0;
    repeat (4) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fft_frame_loader.md
# fft_frame_loader

- Upstream neighbour of the 4-word sample store in the FFT datapath.
- Accepts a stream of N-bit samples over a valid/ready handshake and writes each one into the store with a one-cycle write strobe and a 2-bit address. Addresses are optionally in bit-reversed order, for decimation-in-time input.
- After four samples it flags a complete frame and stalls until the FFT core acknowledges it.

## Interface
Parameters:
- N, 16, sample width in bits
- BITREV, 1, 1 = bit-reversed write addresses (0,2,1,3); 0 = natural order (0,1,2,3)

Ports:
- i_clk  input  1  single clock; all logic on rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_valid  input  1  upstream sample valid
- i_sample  input  N  upstream sample
- o_ready  output  1  loader can accept a sample; registered
- i_flush  input  1  synchronous abort of the current frame
- o_word  output  N  data to the store
- o_address  output  2  store write address
- o_we  output  1  store write strobe, one cycle per sample
- o_frame_valid  output  1  all four words of the frame are written
- i_frame_ack  input  1  consumer has taken the frame
- o_frames  output  8  count of completed frames; wraps at 255 -> 0

## Operation
- **Accept:** a sample is accepted on an edge where i_valid && o_ready.
- **States:**
  - FILL: o_ready=1 and a 2-bit counter cnt is active.
  - LAST: one cycle, o_ready=0.
  - HOLD: o_ready=0, o_frame_valid=1.
- **Transitions:**
  - FILL -> LAST on an accept with cnt==3.
  - LAST -> HOLD unconditionally.
  - HOLD -> FILL on i_frame_ack; cnt is 0 on entry to FILL.
- **Write on accept:** o_word <= i_sample; o_address <= BITREV ? {cnt[0],cnt[1]} : cnt; o_we <= 1; cnt <= cnt+1, wrapping.
- **No accept:** o_we <= 0. o_word and o_address hold their last values.
- **Frame count:** o_frames increments on the LAST -> HOLD transition.
- **Ignored inputs:**
  - i_frame_ack is ignored outside HOLD.
  - i_valid is ignored while o_ready=0. Upstream must hold its sample.
- **i_flush:** synchronous and has the highest priority. Next state FILL, cnt <= 0, o_we <= 0, o_frame_valid <= 0. o_frames is unchanged.
  - A sample presented together with i_flush is discarded and is not written.
  - Store contents are not cleared.
- **Simultaneous i_flush and i_frame_ack in HOLD:** behaves as a flush; the result is identical (FILL).
- **Reset (any time, including mid-frame):**
  - Outputs: o_ready=0, o_word=0, o_address=0, o_we=0, o_frame_valid=0, o_frames=0.
  - State: FILL, cnt=0.
  - o_ready rises at the first rising edge after reset deassertion.

## Timing
- Sample accepted at edge k -> o_we=1 with its o_word/o_address during cycle k+1.
- Back-to-back samples are accepted every cycle in FILL, so four samples take four consecutive cycles.
- Last sample accepted at edge k:
  - o_ready=0 from k+1.
  - Final o_we during cycle k+1.
  - o_frame_valid=1 and o_frames incremented from edge k+2.
- i_frame_ack sampled at edge m in HOLD: o_frame_valid=0 and o_ready=1 from m+1; the earliest new accept is at edge m+1.
- Minimum frame period with a continuous stream and ack pulled high: 4 accept cycles + LAST + 1 HOLD = 6 cycles.
- o_ready, o_frame_valid, o_we, o_word, o_address and o_frames are all registered, with no combinational input-to-output paths.

## Structure
- Shared package fft_pkg holds:
  - DEPTH=4 and ADDR_W=2
  - the loader state enum {FILL, LAST, HOLD}
  - function bitrev2(addr) returning {addr[0],addr[1]}, also reused by the butterfly address logic
- N stays a module parameter.
- No sub-module: a single always_ff for state/counters/outputs plus a next-state block.

## Test plan
1. **Reset release:** i_rst_n low -> all outputs 0. After release, o_ready=1 after one edge, and no o_we before the first accept.
2. **Bit-reversed frame:** BITREV=1, samples 0x1111,0x2222,0x3333,0x4444 on consecutive cycles.
   - Required writes: (0,0x1111),(2,0x2222),(1,0x3333),(3,0x4444).
   - o_frame_valid rises 2 cycles after the last accept; o_frames=1.
3. **Natural order with gaps:** BITREV=0, i_valid toggling 1/0 -> addresses 0,1,2,3 in order, with exactly one o_we per accepted sample.
4. **Backpressure:** hold i_valid=1 with a fifth sample 0x5555 while in HOLD -> no o_we and o_ready=0. Pulse i_frame_ack -> 0x5555 is written at address 0 the cycle after acceptance.
5. **Flush mid-frame:** after two accepts, assert i_flush together with i_valid (0xAAAA) -> 0xAAAA is not written. The next accept writes address 0; o_frames is unchanged.
6. **Async reset while in HOLD:** o_frame_valid drops immediately and o_frames=0, without waiting for a clock edge. The next frame restarts at address 0.
